// File: rtl/dds_cmd_arbiter.sv
// rtl/dds_cmd_arbiter.sv - arbitrates timing-controller and host commands onto one DDS command port
// Issues one command at a time, paces the DDS controller, and holds the readback word until it is consumed.

module dds_cmd_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module dds_cmd_arbiter #(
    parameter int OPCODE_WIDTH    = 16,
    parameter int OPERAND_WIDTH   = 32,
    parameter int CMD_CYCLES      = 33,
    parameter int HOST_FIFO_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tc_valid,
    output logic                     tc_ready,
    input  logic [OPCODE_WIDTH-1:0]  tc_opcode,
    input  logic [OPERAND_WIDTH-1:0] tc_operand,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic [OPCODE_WIDTH-1:0]  host_opcode,
    input  logic [OPERAND_WIDTH-1:0] host_operand,
    output logic                     dds_write_enable,
    output logic [OPCODE_WIDTH-1:0]  dds_opcode,
    output logic [OPERAND_WIDTH-1:0] dds_operand,
    input  logic [31:0]              dds_result_data,
    input  logic                     dds_result_WrReq,
    output logic [31:0]              rd_data,
    output logic                     rd_src,
    output logic                     rd_valid,
    input  logic                     rd_ack,
    output logic                     busy,
    output logic                     err_rd_overflow
);
    localparam int CW = $clog2(CMD_CYCLES + 1);
    localparam int FW = OPCODE_WIDTH + OPERAND_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OPCODE_WIDTH-1:0]  op_q, op_d;
    logic [OPERAND_WIDTH-1:0] opr_q, opr_d;
    logic                     read_src_q, read_src_d;
    logic                     host_pop;
    logic [FW-1:0]            fifo_head;
    logic                     fifo_full, fifo_empty;
    logic                     wrreq_prev_q, wr_edge;
    logic [31:0]              rd_data_q;
    logic                     rd_valid_q, rd_src_q, err_q;

    function automatic logic is_read(input logic [OPCODE_WIDTH-1:0] op);
        return (op[3:0] == 4'd3) || (op[3:0] == 4'd14);
    endfunction

    dds_cmd_fifo #(.WIDTH(FW), .DEPTH(HOST_FIFO_DEPTH)) u_host_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (host_valid),
        .wdata_i ({host_opcode, host_operand}),
        .pop_i   (host_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            opr_q      <= '0;
            read_src_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opr_q      <= opr_d;
            read_src_q <= read_src_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opr_d      = opr_q;
        read_src_d = read_src_q;
        host_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Timing-controller commands always win over queued host commands.
                if (tc_valid) begin
                    op_d    = tc_opcode;
                    opr_d   = tc_operand;
                    state_d = S_ISSUE;
                    if (is_read(tc_opcode)) read_src_d = 1'b0;
                end else if (!fifo_empty) begin
                    op_d     = fifo_head[FW-1:OPERAND_WIDTH];
                    opr_d    = fifo_head[OPERAND_WIDTH-1:0];
                    host_pop = 1'b1;
                    state_d  = S_ISSUE;
                    if (is_read(fifo_head[FW-1:OPERAND_WIDTH])) read_src_d = 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(CMD_CYCLES - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_edge = dds_result_WrReq && !wrreq_prev_q;

    // A readback replaces the held word only when the slot is free or freed this same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrreq_prev_q <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_src_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wrreq_prev_q <= dds_result_WrReq;
            if (wr_edge && (!rd_valid_q || rd_ack)) begin
                rd_data_q  <= dds_result_data;
                rd_valid_q <= 1'b1;
                rd_src_q   <= read_src_q;
            end else if (wr_edge) begin
                err_q <= 1'b1;
            end else if (rd_ack) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign tc_ready         = (state_q == S_IDLE) && !reset;
    assign host_ready       = !fifo_full;
    assign dds_write_enable = (state_q == S_ISSUE);
    assign busy             = (state_q != S_IDLE);
    assign dds_opcode       = op_q;
    assign dds_operand      = opr_q;
    assign rd_data          = rd_data_q;
    assign rd_valid         = rd_valid_q;
    assign rd_src           = rd_src_q;
    assign err_rd_overflow  = err_q;
endmodule

// File: tb/tb_dds_cmd_arbiter.sv
// tb/tb_dds_cmd_arbiter.sv - directed and randomized checks of dds_cmd_arbiter against a queue model

module tb_dds_cmd_arbiter;
    localparam int OW = 16;
    localparam int PW = 32;
    localparam int C  = 33;
    localparam int D  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          tc_valid, tc_ready;
    logic [OW-1:0] tc_opcode;
    logic [PW-1:0] tc_operand;
    logic          host_valid, host_ready;
    logic [OW-1:0] host_opcode;
    logic [PW-1:0] host_operand;
    logic          dds_write_enable;
    logic [OW-1:0] dds_opcode;
    logic [PW-1:0] dds_operand;
    logic [31:0]   dds_result_data;
    logic          dds_result_WrReq;
    logic [31:0]   rd_data;
    logic          rd_src, rd_valid, rd_ack, busy, err_rd_overflow;

    dds_cmd_arbiter #(.OPCODE_WIDTH(OW), .OPERAND_WIDTH(PW), .CMD_CYCLES(C), .HOST_FIFO_DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .tc_valid(tc_valid), .tc_ready(tc_ready), .tc_opcode(tc_opcode), .tc_operand(tc_operand),
        .host_valid(host_valid), .host_ready(host_ready), .host_opcode(host_opcode), .host_operand(host_operand),
        .dds_write_enable(dds_write_enable), .dds_opcode(dds_opcode), .dds_operand(dds_operand),
        .dds_result_data(dds_result_data), .dds_result_WrReq(dds_result_WrReq),
        .rd_data(rd_data), .rd_src(rd_src), .rd_valid(rd_valid), .rd_ack(rd_ack),
        .busy(busy), .err_rd_overflow(err_rd_overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [OW-1:0] iss_op[$];
    logic [PW-1:0] iss_opr[$];
    int            iss_cyc[$];
    always @(negedge clock) begin
        if (dds_write_enable === 1'b1) begin
            iss_op.push_back(dds_opcode);
            iss_opr.push_back(dds_operand);
            iss_cyc.push_back(cyc);
        end
    end

    int n_asserts = 0;
    int n_fail    = 0;
    logic [OW+PW-1:0] exp_cmds[$];
    logic [OW+PW-1:0] host_model[$];
    logic [OW-1:0]    t_op;
    logic [PW-1:0]    t_opr;
    logic [31:0]      d0, d1;
    int base, hs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        check("wait_idle_bound", 64'(busy), 64'd0);
    endtask

    task automatic wait_issue(input int budget);
        int n = 0;
        while (dds_write_enable !== 1'b1 && n < budget) begin tick(); n++; end
        check("wait_issue_bound", 64'(dds_write_enable), 64'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [OW-1:0] rand_op();
        logic [OW-1:0] v;
        v = OW'($urandom);
        v[3:0] = 4'h5;
        return v;
    endfunction

    // Issues since base must equal exp_cmds in order, first one handshake+1, then CMD_CYCLES+2 apart.
    task automatic verify_issues(input int b, input int h);
        check("issue_count", 64'(iss_op.size() - b), 64'(exp_cmds.size()));
        if (iss_op.size() >= b + exp_cmds.size()) begin
            check("first_latency", 64'(iss_cyc[b] - h), 64'd1);
            for (int i = 0; i < exp_cmds.size(); i++) begin
                check("issue_opcode", 64'(iss_op[b+i]), 64'(exp_cmds[i][OW+PW-1:PW]));
                check("issue_operand", 64'(iss_opr[b+i]), 64'(exp_cmds[i][PW-1:0]));
                if (i > 0) check("issue_spacing", 64'(iss_cyc[b+i] - iss_cyc[b+i-1]), 64'(C + 2));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        tc_valid = 0; tc_opcode = '0; tc_operand = '0;
        host_valid = 0; host_opcode = '0; host_operand = '0;
        dds_result_data = '0; dds_result_WrReq = 0; rd_ack = 0;
        run(3);
        check("rst_we", 64'(dds_write_enable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tc_ready", 64'(tc_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_err", 64'(err_rd_overflow), 64'd0);
        check("rst_opcode", 64'(dds_opcode), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_host_ready", 64'(host_ready), 64'd1);
        check("post_rst_tc_ready", 64'(tc_ready), 64'd1);

        // Single tc command: latency, hold, busy window.
        tc_valid = 1; tc_opcode = 16'h0010; tc_operand = 32'h12345678;
        tick();
        tc_valid = 0;
        check("tc_we", 64'(dds_write_enable), 64'd1);
        check("tc_opcode", 64'(dds_opcode), 64'h0010);
        check("tc_operand", 64'(dds_operand), 64'h12345678);
        check("tc_busy_issue", 64'(busy), 64'd1);
        for (int i = 1; i <= C; i++) begin
            tick();
            check("wait_busy", 64'(busy), 64'd1);
            check("wait_tc_ready", 64'(tc_ready), 64'd0);
            check("wait_we", 64'(dds_write_enable), 64'd0);
            check("wait_hold", 64'({dds_opcode, dds_operand}), 64'h0010_12345678);
        end
        tick();
        check("done_busy", 64'(busy), 64'd0);
        check("done_tc_ready", 64'(tc_ready), 64'd1);

        // FIFO overflow while busy: five random host pushes, depth four.
        exp_cmds.delete(); host_model.delete();
        base = iss_op.size();
        t_op = rand_op(); t_opr = $urandom;
        exp_cmds.push_back({t_op, t_opr});
        tc_valid = 1; tc_opcode = t_op; tc_operand = t_opr; hs = cyc;
        tick();
        tc_valid = 0;
        for (int i = 0; i < 5; i++) begin
            t_op = rand_op(); t_opr = $urandom;
            host_valid = 1; host_opcode = t_op; host_operand = t_opr;
            check("push_host_ready", 64'(host_ready), 64'(host_model.size() < D));
            if (host_model.size() < D) host_model.push_back({t_op, t_opr});
            tick();
        end
        host_valid = 0;
        check("full_host_ready", 64'(host_ready), 64'd0);
        foreach (host_model[i]) exp_cmds.push_back(host_model[i]);
        run(5 * (C + 2) + 10);
        verify_issues(base, hs);

        // Priority: host entry queued and tc request in the same IDLE cycle.
        wait_idle(C + 5);
        exp_cmds.delete();
        base = iss_op.size();
        t_op = rand_op(); t_opr = $urandom;
        host_valid = 1; host_opcode = t_op; host_operand = t_opr;
        tick();
        host_valid = 0;
        d0 = $urandom;
        tc_valid = 1; tc_opcode = rand_op(); tc_operand = d0; hs = cyc;
        check("prio_tc_ready", 64'(tc_ready), 64'd1);
        exp_cmds.push_back({tc_opcode, d0});
        exp_cmds.push_back({t_op, t_opr});
        tick();
        tc_valid = 0;
        run(2 * (C + 2) + 10);
        verify_issues(base, hs);

        // Readback: host read, tc read with same-cycle ack, level WrReq, overflow.
        wait_idle(C + 5);
        host_valid = 1; host_opcode = 16'h0003; host_operand = $urandom;
        tick();
        host_valid = 0;
        wait_issue(10);
        dds_result_WrReq = 1; dds_result_data = 32'h0000BEEF;
        tick();
        dds_result_WrReq = 0;
        check("rd_data_beef", 64'(rd_data), 64'h0000BEEF);
        check("rd_src_host", 64'(rd_src), 64'd1);
        check("rd_valid_set", 64'(rd_valid), 64'd1);
        check("rd_err_clear", 64'(err_rd_overflow), 64'd0);
        wait_idle(C + 5);
        tc_valid = 1; tc_opcode = 16'h001E; tc_operand = $urandom;
        tick();
        tc_valid = 0;
        d0 = $urandom;
        dds_result_WrReq = 1; dds_result_data = d0; rd_ack = 1;
        tick();
        dds_result_WrReq = 0;
        check("ack_same_data", 64'(rd_data), 64'(d0));
        check("ack_same_src", 64'(rd_src), 64'd0);
        check("ack_same_valid", 64'(rd_valid), 64'd1);
        check("ack_same_err", 64'(err_rd_overflow), 64'd0);
        tick();
        check("ack_clears", 64'(rd_valid), 64'd0);
        tick();
        rd_ack = 0;
        check("ack_idle_valid", 64'(rd_valid), 64'd0);
        check("ack_idle_err", 64'(err_rd_overflow), 64'd0);
        d1 = $urandom;
        for (int i = 0; i < 3; i++) begin
            dds_result_WrReq = 1; dds_result_data = d1 + 32'(i);
            tick();
        end
        dds_result_WrReq = 0;
        check("level_data", 64'(rd_data), 64'(d1));
        check("level_err", 64'(err_rd_overflow), 64'd0);
        tick();
        dds_result_WrReq = 1; dds_result_data = ~d1;
        tick();
        dds_result_WrReq = 0;
        check("ovf_err", 64'(err_rd_overflow), 64'd1);
        check("ovf_data", 64'(rd_data), 64'(d1));
        check("ovf_valid", 64'(rd_valid), 64'd1);

        // Reset mid-WAIT with two host entries queued.
        wait_idle(C + 5);
        tc_valid = 1; tc_opcode = rand_op(); tc_operand = $urandom;
        tick();
        tc_valid = 0;
        for (int i = 0; i < 2; i++) begin
            host_valid = 1; host_opcode = rand_op(); host_operand = $urandom;
            tick();
        end
        host_valid = 0;
        run(5);
        base = iss_op.size();
        reset = 1;
        tick();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_we", 64'(dds_write_enable), 64'd0);
        check("mid_rst_err", 64'(err_rd_overflow), 64'd0);
        check("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
        reset = 0;
        tick();
        check("after_rst_we", 64'(dds_write_enable), 64'd0);
        check("after_rst_host_ready", 64'(host_ready), 64'd1);
        run(C + 10);
        check("after_rst_no_issue", 64'(iss_op.size() - base), 64'd0);
        check("after_rst_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
